// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding and default width.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_negate.sv
// Conditional two's-complement negate, used for operand magnitudes and result sign fixing.
module div_negate #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             neg,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  assign dout = neg ? (~din + WIDTH'(1)) : din;

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider with MIPS DIV/DIVU semantics (truncating quotient,
// remainder carries the dividend sign).
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH     = DIV_WIDTH,
  parameter int unsigned SIGNED_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             div_end,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH);

  div_state_t state, state_n;

  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvsr;
  logic [CW-1:0]    cnt;
  logic             sign_q;
  logic             sign_r;

  logic             sgn_c;
  logic             dvd_neg_c;
  logic             dvs_neg_c;
  logic             dvs_zero_c;
  logic [WIDTH-1:0] dvd_mag_c;
  logic [WIDTH-1:0] dvs_mag_c;
  logic [WIDTH-1:0] quo_fix_c;
  logic [WIDTH-1:0] rem_fix_c;
  logic [WIDTH:0]   shifted_c;
  logic [WIDTH-1:0] diff_c;
  logic             ge_c;

  assign sgn_c      = (SIGNED_EN != 0) && is_signed;
  assign dvd_neg_c  = sgn_c && dividend[WIDTH-1];
  assign dvs_neg_c  = sgn_c && divisor[WIDTH-1];
  assign dvs_zero_c = (divisor == '0);

  div_negate #(.WIDTH(WIDTH)) u_neg_dvd (.neg(dvd_neg_c), .din(dividend),  .dout(dvd_mag_c));
  div_negate #(.WIDTH(WIDTH)) u_neg_dvs (.neg(dvs_neg_c), .din(divisor),   .dout(dvs_mag_c));
  div_negate #(.WIDTH(WIDTH)) u_neg_quo (.neg(sign_q),    .din(quo),       .dout(quo_fix_c));
  div_negate #(.WIDTH(WIDTH)) u_neg_rem (.neg(sign_r),    .din(rem),       .dout(rem_fix_c));

  // Partial remainder is WIDTH+1 bits; when the trial subtract succeeds the difference
  // is below the divisor, so the low WIDTH bits of the modular subtract are exact.
  assign shifted_c = {rem, quo[WIDTH-1]};
  assign ge_c      = (shifted_c >= {1'b0, dvsr});
  assign diff_c    = shifted_c[WIDTH-1:0] - dvsr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (div_start) state_n = dvs_zero_c ? DONE : CALC;
      CALC:    if (cnt == CW'(WIDTH - 1)) state_n = FIX;
      FIX:     state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Datapath and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy        <= 1'b0;
      div_end     <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      quo         <= '0;
      rem         <= '0;
      dvsr        <= '0;
      cnt         <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
    end else begin
      busy    <= (state_n == CALC) || (state_n == FIX);
      div_end <= (state == DONE);
      case (state)
        IDLE: begin
          if (div_start) begin
            if (dvs_zero_c) begin
              div_by_zero <= 1'b1;
            end else begin
              div_by_zero <= 1'b0;
              quo         <= dvd_mag_c;
              dvsr        <= dvs_mag_c;
              rem         <= '0;
              cnt         <= '0;
              sign_q      <= dvd_neg_c ^ dvs_neg_c;
              sign_r      <= dvd_neg_c;
            end
          end
        end
        CALC: begin
          quo <= {quo[WIDTH-2:0], ge_c};
          rem <= ge_c ? diff_c : shifted_c[WIDTH-1:0];
          cnt <= cnt + CW'(1);
        end
        FIX: begin
          lo <= quo_fix_c;
          hi <= rem_fix_c;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: 32-bit and 8-bit instances, hand-computed results.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        div_start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] dividend  = '0;
  logic [31:0] divisor   = '0;
  logic        busy, div_end, div_by_zero;
  logic [31:0] hi, lo;

  logic        div_start8 = 1'b0;
  logic        is_signed8 = 1'b0;
  logic [7:0]  dividend8  = '0;
  logic [7:0]  divisor8   = '0;
  logic        busy8, div_end8, div_by_zero8;
  logic [7:0]  hi8, lo8;

  int asserts  = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(32), .SIGNED_EN(1)) dut (
    .clk(clk), .rst(rst), .div_start(div_start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .busy(busy), .div_end(div_end),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  seq_divider #(.WIDTH(8), .SIGNED_EN(1)) dut8 (
    .clk(clk), .rst(rst), .div_start(div_start8), .is_signed(is_signed8),
    .dividend(dividend8), .divisor(divisor8), .busy(busy8), .div_end(div_end8),
    .div_by_zero(div_by_zero8), .hi(hi8), .lo(lo8)
  );

  // Issue one 32-bit op; lat = edges from accept to div_end (-1 on timeout).
  task automatic run32(input logic sg, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int busy_cyc);
    @(negedge clk);
    is_signed = sg; dividend = a; divisor = b; div_start = 1'b1;
    @(posedge clk); #1;
    div_start = 1'b0;
    lat = -1;
    busy_cyc = busy ? 1 : 0;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (div_end) begin lat = n; break; end
      if (busy) busy_cyc++;
    end
  endtask

  task automatic run8(input logic sg, input logic [7:0] a, input logic [7:0] b,
                      output int lat);
    @(negedge clk);
    is_signed8 = sg; dividend8 = a; divisor8 = b; div_start8 = 1'b1;
    @(posedge clk); #1;
    div_start8 = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (div_end8) begin lat = n; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    asserts++; if (busy !== 1'b0) begin failures++; $display("FAIL reset busy: got %b expected 0", busy); end
    asserts++; if (div_end !== 1'b0) begin failures++; $display("FAIL reset div_end: got %b expected 0", div_end); end
    asserts++; if (div_by_zero !== 1'b0) begin failures++; $display("FAIL reset div_by_zero: got %b expected 0", div_by_zero); end
    asserts++; if (hi !== 32'd0) begin failures++; $display("FAIL reset hi: got %h expected 0", hi); end
    asserts++; if (lo !== 32'd0) begin failures++; $display("FAIL reset lo: got %h expected 0", lo); end
    asserts++; if ({hi8, lo8} !== 16'd0) begin failures++; $display("FAIL reset hi8/lo8: got %h expected 0", {hi8, lo8}); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_signed_basic();
    int lat, bc;
    run32(1'b1, 32'd100, 32'd7, lat, bc);
    asserts++; if (lat !== 34) begin failures++; $display("FAIL 100/7 latency: got %0d expected 34", lat); end
    asserts++; if (bc !== 33) begin failures++; $display("FAIL 100/7 busy cycles: got %0d expected 33", bc); end
    asserts++; if (lo !== 32'd14) begin failures++; $display("FAIL 100/7 lo: got %h expected %h", lo, 32'd14); end
    asserts++; if (hi !== 32'd2) begin failures++; $display("FAIL 100/7 hi: got %h expected %h", hi, 32'd2); end
    @(posedge clk); #1;
    asserts++; if (div_end !== 1'b0) begin failures++; $display("FAIL div_end width: got %b expected 0", div_end); end
  endtask

  task automatic test_signed_neg();
    int lat, bc;
    run32(1'b1, 32'hFFFF_FFF9, 32'd2, lat, bc);
    asserts++; if (lo !== 32'hFFFF_FFFD) begin failures++; $display("FAIL -7/2 lo: got %h expected FFFFFFFD", lo); end
    asserts++; if (hi !== 32'hFFFF_FFFF) begin failures++; $display("FAIL -7/2 hi: got %h expected FFFFFFFF", hi); end
    run32(1'b1, 32'd7, 32'hFFFF_FFFE, lat, bc);
    asserts++; if (lo !== 32'hFFFF_FFFD) begin failures++; $display("FAIL 7/-2 lo: got %h expected FFFFFFFD", lo); end
    asserts++; if (hi !== 32'd1) begin failures++; $display("FAIL 7/-2 hi: got %h expected 1", hi); end
  endtask

  task automatic test_unsigned();
    int lat, bc;
    run32(1'b0, 32'hFFFF_FFFF, 32'd1, lat, bc);
    asserts++; if (lo !== 32'hFFFF_FFFF) begin failures++; $display("FAIL u max/1 lo: got %h expected FFFFFFFF", lo); end
    asserts++; if (hi !== 32'd0) begin failures++; $display("FAIL u max/1 hi: got %h expected 0", hi); end
    run32(1'b0, 32'hFFFF_FFF9, 32'd2, lat, bc);
    asserts++; if (lo !== 32'h7FFF_FFFC) begin failures++; $display("FAIL u FFFFFFF9/2 lo: got %h expected 7FFFFFFC", lo); end
    asserts++; if (hi !== 32'd1) begin failures++; $display("FAIL u FFFFFFF9/2 hi: got %h expected 1", hi); end
  endtask

  task automatic test_overflow();
    int lat, bc;
    run32(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc);
    asserts++; if (lo !== 32'h8000_0000) begin failures++; $display("FAIL MIN/-1 lo: got %h expected 80000000", lo); end
    asserts++; if (hi !== 32'd0) begin failures++; $display("FAIL MIN/-1 hi: got %h expected 0", hi); end
    asserts++; if (div_by_zero !== 1'b0) begin failures++; $display("FAIL MIN/-1 flag: got %b expected 0", div_by_zero); end
  endtask

  task automatic test_div_zero();
    int lat, bc;
    run32(1'b1, 32'd86, 32'd9, lat, bc);
    asserts++; if ({hi, lo} !== {32'd5, 32'd9}) begin failures++; $display("FAIL 86/9 hi/lo: got %h/%h expected 5/9", hi, lo); end
    run32(1'b1, 32'd123, 32'd0, lat, bc);
    asserts++; if (lat !== 1) begin failures++; $display("FAIL div0 latency: got %0d expected 1", lat); end
    asserts++; if (div_by_zero !== 1'b1) begin failures++; $display("FAIL div0 flag: got %b expected 1", div_by_zero); end
    asserts++; if (hi !== 32'd5) begin failures++; $display("FAIL div0 hi held: got %h expected 5", hi); end
    asserts++; if (lo !== 32'd9) begin failures++; $display("FAIL div0 lo held: got %h expected 9", lo); end
    run32(1'b1, 32'd9, 32'd3, lat, bc);
    asserts++; if (div_by_zero !== 1'b0) begin failures++; $display("FAIL 9/3 flag clear: got %b expected 0", div_by_zero); end
    asserts++; if (lo !== 32'd3) begin failures++; $display("FAIL 9/3 lo: got %h expected 3", lo); end
    asserts++; if (hi !== 32'd0) begin failures++; $display("FAIL 9/3 hi: got %h expected 0", hi); end
  endtask

  // A second start while busy must be dropped, not queued.
  task automatic test_busy_ignore();
    int lat;
    int extra;
    @(negedge clk);
    is_signed = 1'b1; dividend = 32'd1000; divisor = 32'd10; div_start = 1'b1;
    @(posedge clk); #1;
    div_start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (div_end) begin lat = n; break; end
      if (n == 5) begin dividend = 32'd7; divisor = 32'd7; div_start = 1'b1; end
      if (n == 6) div_start = 1'b0;
    end
    asserts++; if (lat !== 34) begin failures++; $display("FAIL busy-ignore latency: got %0d expected 34", lat); end
    asserts++; if (lo !== 32'd100) begin failures++; $display("FAIL busy-ignore lo: got %h expected %h", lo, 32'd100); end
    asserts++; if (hi !== 32'd0) begin failures++; $display("FAIL busy-ignore hi: got %h expected 0", hi); end
    extra = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (div_end || busy) extra++;
    end
    asserts++; if (extra !== 0) begin failures++; $display("FAIL busy-ignore queued op: got %0d active cycles expected 0", extra); end
  endtask

  task automatic test_reset_mid();
    int lat, bc, ends;
    @(negedge clk);
    is_signed = 1'b1; dividend = 32'd123456; divisor = 32'd7; div_start = 1'b1;
    @(posedge clk); #1;
    div_start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    asserts++; if ({busy, div_end, div_by_zero} !== 3'b000) begin failures++; $display("FAIL mid-reset flags: got %b expected 000", {busy, div_end, div_by_zero}); end
    asserts++; if ({hi, lo} !== 64'd0) begin failures++; $display("FAIL mid-reset hi/lo: got %h expected 0", {hi, lo}); end
    @(negedge clk);
    rst = 1'b0;
    ends = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (div_end) ends++;
    end
    asserts++; if (ends !== 0) begin failures++; $display("FAIL mid-reset div_end count: got %0d expected 0", ends); end
    run32(1'b1, 32'd50, 32'd5, lat, bc);
    asserts++; if (lo !== 32'd10) begin failures++; $display("FAIL post-reset 50/5 lo: got %h expected %h", lo, 32'd10); end
    asserts++; if (hi !== 32'd0) begin failures++; $display("FAIL post-reset 50/5 hi: got %h expected 0", hi); end
    asserts++; if (lat !== 34) begin failures++; $display("FAIL post-reset latency: got %0d expected 34", lat); end
  endtask

  task automatic test_width8();
    int lat;
    run8(1'b1, 8'h80, 8'd3, lat);
    asserts++; if (lat !== 10) begin failures++; $display("FAIL w8 latency: got %0d expected 10", lat); end
    asserts++; if (lo8 !== 8'hD6) begin failures++; $display("FAIL w8 -128/3 lo: got %h expected D6", lo8); end
    asserts++; if (hi8 !== 8'hFE) begin failures++; $display("FAIL w8 -128/3 hi: got %h expected FE", hi8); end
    run8(1'b0, 8'd200, 8'd7, lat);
    asserts++; if (lo8 !== 8'd28) begin failures++; $display("FAIL w8 200/7 lo: got %h expected %h", lo8, 8'd28); end
    asserts++; if (hi8 !== 8'd4) begin failures++; $display("FAIL w8 200/7 hi: got %h expected 4", hi8); end
  endtask

  initial begin
    test_reset();
    test_signed_basic();
    test_signed_neg();
    test_unsigned();
    test_overflow();
    test_div_zero();
    test_busy_ignore();
    test_reset_mid();
    test_width8();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width in bits (legal 4..64).
REQ-002 SHALL have parameter SIGNED_EN, default 1, meaning signed mode is supported; when 0, is_signed is ignored and treated as 0.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port div_start, input, 1 bit: operation request, sampled only in IDLE.
REQ-006 SHALL have port is_signed, input, 1 bit: 1 = DIV (two's complement), 0 = DIVU; sampled with div_start.
REQ-007 SHALL have port dividend, input, WIDTH bits: numerator, sampled with div_start.
REQ-008 SHALL have port divisor, input, WIDTH bits: denominator, sampled with div_start.
REQ-009 SHALL have port busy, output, 1 bit: high from the accept edge until div_end is asserted.
REQ-010 SHALL have port div_end, output, 1 bit: single-cycle completion pulse.
REQ-011 SHALL have port div_by_zero, output, 1 bit: status of the last completed operation.
REQ-012 SHALL have port hi, output, WIDTH bits: remainder.
REQ-013 SHALL have port lo, output, WIDTH bits: quotient.

Function
REQ-014 SHALL implement the FSM states IDLE, CALC, FIX and DONE.
REQ-015 SHALL accept an operation at an edge in IDLE with div_start=1; the transition is IDLE->CALC, or IDLE->DONE when divisor==0.
REQ-016 SHALL ignore div_start in every state other than IDLE; no queuing.
REQ-017 SHALL convert operands to magnitudes when signed mode is active, latching sign_q = dividend MSB XOR divisor MSB and sign_r = dividend MSB.
REQ-018 SHALL in CALC perform radix-2 restoring division, one quotient bit per cycle, MSB first, for exactly WIDTH cycles using a WIDTH+1-bit partial remainder; then CALC->FIX.
REQ-019 SHALL in FIX negate the quotient if sign_q and negate the remainder if sign_r, register them to lo/hi, and go FIX->DONE.
REQ-020 SHALL in DONE assert div_end for one cycle and go DONE->IDLE; busy is low in DONE.
REQ-021 SHALL produce valid results with div_end at exactly WIDTH+2 edges after the accept edge, i.e. 34 for WIDTH=32.
REQ-022 SHALL follow MIPS rounding semantics: quotient truncates toward zero, remainder takes the sign of the dividend, and dividend == quotient*divisor + remainder.
REQ-023 SHALL return, for signed MIN / -1, lo = MIN and hi = 0, with no flag.
REQ-024 SHALL on divisor==0 leave hi/lo unchanged, set div_by_zero=1, and pulse div_end 1 edge after accept.
REQ-025 SHALL hold hi, lo and div_by_zero stable from div_end until the next completion; div_by_zero clears at the next accept of a nonzero-divisor operation.
REQ-026 SHALL accept a new operation in the IDLE cycle immediately after DONE, giving a back-to-back throughput of one operation per WIDTH+3 cycles.

Reset
REQ-027 SHALL on rst=1 asynchronously force state=IDLE, busy=0, div_end=0, div_by_zero=0, hi=0, lo=0 and clear all internal registers.
REQ-028 SHALL abort an in-flight operation on reset mid-operation with no div_end pulse; the first operation accepted after rst deasserts produces a correct result.

Structure
REQ-029 SHALL take the state enumeration (IDLE/CALC/FIX/DONE) and the default width constant DIV_WIDTH=32 from shared package div_pkg.
REQ-030 SHALL place the one-cycle conditional two's-complement negate in sub-module div_negate (parameter WIDTH), instantiated for operand and result sign fixing; everything else stays in seq_divider.

Verification
REQ-031 SHALL verify: signed 100 / 7 -> lo=14, hi=2, div_end exactly 34 edges after accept, busy high 33 cycles.
REQ-032 SHALL verify: signed -7 / 2 -> lo=-3 (0xFFFFFFFD), hi=-1; signed 7 / -2 -> lo=-3, hi=1.
REQ-033 SHALL verify: unsigned 0xFFFFFFFF / 1 -> lo=0xFFFFFFFF, hi=0; signed 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-034 SHALL verify: divisor 0 with hi/lo previously 5/9 -> div_by_zero=1, hi=5, lo=9, div_end 1 edge after accept; the next 9/3 clears the flag and gives lo=3, hi=0.
REQ-035 SHALL verify: div_start pulsed while busy -> ignored, and the first result is unchanged; rst asserted at cycle 10 of CALC -> outputs 0, no div_end; the following 50/5 gives lo=10, hi=0.
REQ-036 SHALL verify: WIDTH=8 instance, signed -128 / 3 -> lo=-42 (0xD6), hi=-2 (0xFE), div_end 10 edges after accept.
